// File: rtl/alu32_decoder_if.sv
// Operand/instruction bus into the ALU decoder and its registered result bus.
interface alu32_decoder_if;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        out_valid;
    logic [31:0] q;
    logic        cf;
    logic        of;
    logic        zf;
    logic        illegal;

    modport master (
        output in_valid, instruction, alu_a, alu_b,
        input  out_valid, q, cf, of, zf, illegal
    );

    modport slave (
        input  in_valid, instruction, alu_a, alu_b,
        output out_valid, q, cf, of, zf, illegal
    );
endinterface

// File: rtl/alu32_decoder.sv
// MIPS-style instruction decoder and 32-bit ALU with a one-cycle registered result.
// Optional macro ALU32_OVF_EN builds the signed-overflow flag; otherwise of is tied to 0.
module alu32_decoder (
    input  logic              clk,
    input  logic              rst_n,
    alu32_decoder_if.slave    bus
);

    typedef enum logic [3:0] {
        OP_ZERO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI
    } alu_op_e;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, shamt;

    assign opcode = bus.instruction[31:26];
    assign rs     = bus.instruction[25:21];
    assign rt     = bus.instruction[20:16];
    assign shamt  = bus.instruction[10:6];
    assign funct  = bus.instruction[5:0];

    // rd is meaningless to an ALU that only produces a value.
    logic unused_rd;
    assign unused_rd = ^bus.instruction[15:11];

    alu_op_e op;
    logic    illegal_d;
    logic    var_shift;
`ifdef ALU32_OVF_EN
    logic    ovf_chk;
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        op        = OP_ZERO;
        illegal_d = 1'b0;
        var_shift = 1'b0;
`ifdef ALU32_OVF_EN
        ovf_chk   = 1'b0;
`endif
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin
                        op = OP_ADD;
`ifdef ALU32_OVF_EN
                        ovf_chk = 1'b1;
`endif
                    end
                    6'b100001: op = OP_ADD;
                    6'b100010: begin
                        op = OP_SUB;
`ifdef ALU32_OVF_EN
                        ovf_chk = 1'b1;
`endif
                    end
                    6'b100011: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
                    6'b000011: op = OP_SRA;
                    6'b000100: begin op = OP_SLL; var_shift = 1'b1; end
                    6'b000110: begin op = OP_SRL; var_shift = 1'b1; end
                    6'b000111: begin op = OP_SRA; var_shift = 1'b1; end
                    6'b001000, 6'b001001, 6'b001100, 6'b001101,
                    6'b010000, 6'b010001, 6'b010010, 6'b010011,
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: op = OP_ZERO;
                    default:   illegal_d = 1'b1;
                endcase
            end
            6'b001000: begin
                op = OP_ADD;
`ifdef ALU32_OVF_EN
                ovf_chk = 1'b1;
`endif
            end
            6'b001001: op = OP_ADD;
            6'b001010: op = OP_SLT;
            6'b001011: op = OP_SLTU;
            6'b001100: op = OP_AND;
            6'b001101: op = OP_OR;
            6'b001110: op = OP_XOR;
            6'b001111: op = OP_LUI;
            6'b000100, 6'b000101: op = OP_SUB;
            6'b100000, 6'b100001, 6'b100011, 6'b100100,
            6'b100101, 6'b101000, 6'b101001, 6'b101011: op = OP_ADD;
            6'b000010, 6'b000011, 6'b000110, 6'b000111: op = OP_ZERO;
            6'b000001: illegal_d = !(rt inside {5'b00000, 5'b00001, 5'b10000, 5'b10001});
            6'b010000: illegal_d = !((rs == 5'b00000) || (rs == 5'b00100) ||
                                     (rs[4] && funct == 6'b011000));
            default:   illegal_d = 1'b1;
        endcase
    end

    logic [32:0] sum, diff;
    logic [4:0]  sh_amt;
    logic [31:0] res;
    logic        carry;
    logic        ovf;

    assign sum    = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign diff   = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
    assign sh_amt = var_shift ? bus.alu_a[4:0] : shamt;

    always_comb begin
        res   = 32'h0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[31:0];
                carry = sum[32];
`ifdef ALU32_OVF_EN
                ovf   = ovf_chk && (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
`endif
            end
            OP_SUB: begin
                // Bit 32 of the zero-extended difference is the unsigned borrow.
                res   = diff[31:0];
                carry = diff[32];
`ifdef ALU32_OVF_EN
                ovf   = ovf_chk && (bus.alu_a[31] != bus.alu_b[31]) && (diff[31] != bus.alu_a[31]);
`endif
            end
            OP_AND:  res = bus.alu_a & bus.alu_b;
            OP_OR:   res = bus.alu_a | bus.alu_b;
            OP_XOR:  res = bus.alu_a ^ bus.alu_b;
            OP_NOR:  res = ~(bus.alu_a | bus.alu_b);
            OP_SLT:  res = {31'h0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            OP_SLTU: res = {31'h0, bus.alu_a < bus.alu_b};
            OP_SLL:  res = bus.alu_b << sh_amt;
            OP_SRL:  res = bus.alu_b >> sh_amt;
            OP_SRA:  res = 32'($signed(bus.alu_b) >>> sh_amt);
            OP_LUI:  res = {bus.alu_b[15:0], 16'h0000};
            default: res = 32'h0;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.q         <= 32'h0;
            bus.cf        <= 1'b0;
            bus.of        <= 1'b0;
            bus.zf        <= 1'b1;
            bus.illegal   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.q       <= res;
                bus.cf      <= carry;
                bus.of      <= ovf;
                bus.zf      <= (res == 32'h0);
                bus.illegal <= illegal_d;
            end
        end
    end

endmodule

// File: tb/tb_alu32_decoder.sv
// Directed-vector bench for alu32_decoder; expected results are hand-computed.
module tb_alu32_decoder;

`ifdef ALU32_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    alu32_decoder_if bus();

    alu32_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit ev, input logic [31:0] eq,
                              input bit ecf, input bit eof, input bit eill);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, ".q"},         bus.q,              eq);
        check({tag, ".cf"},        32'(bus.cf),        32'(ecf));
        check({tag, ".of"},        32'(bus.of),        32'(eof));
        check({tag, ".zf"},        32'(bus.zf),        32'(eq == 32'h0));
        check({tag, ".illegal"},   32'(bus.illegal),   32'(eill));
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid    = 1'b1;
        bus.instruction = instr;
        bus.alu_a       = a;
        bus.alu_b       = b;
    endtask

    task automatic run(input string tag, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq,
                       input bit ecf, input bit eof, input bit eill);
        @(negedge clk);
        drive(instr, a, b);
        @(posedge clk);
        #1;
        expect_out(tag, 1'b1, eq, ecf, eof, eill);
    endtask

    function automatic logic [31:0] rt_(input logic [5:0] funct, input logic [4:0] shamt);
        return {6'b000000, 15'h0, shamt, funct};
    endfunction

    function automatic logic [31:0] it_(input logic [5:0] opc);
        return {opc, 26'h0};
    endfunction

    initial begin
        bus.in_valid    = 1'b0;
        bus.instruction = 32'h0;
        bus.alu_a       = 32'h0;
        bus.alu_b       = 32'h0;
        repeat (3) @(negedge clk);
        expect_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run("add_ovf",   rt_(6'b100000, 0), 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, OVF, 0);
        run("addu_wrap", rt_(6'b100001, 0), 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0);
        run("addi_ovf",  it_(6'b001000),    32'h7FFFFFFF, 32'h1, 32'h80000000, 0, OVF, 0);
        run("lw_add",    it_(6'b100011),    32'h10,       32'h4, 32'h14, 0, 0, 0);
        run("subu_brw",  rt_(6'b100011, 0), 32'h0,        32'h1, 32'hFFFFFFFF, 1, 0, 0);

        // Idle cycle with changed inputs must leave results untouched.
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.instruction = rt_(6'b100001, 0);
        bus.alu_a       = 32'h5;
        bus.alu_b       = 32'h5;
        @(posedge clk);
        #1;
        expect_out("hold", 1'b0, 32'hFFFFFFFF, 1, 0, 0);

        run("sub_ovf",   rt_(6'b100010, 0), 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, OVF, 0);
        run("beq_eq",    it_(6'b000100),    32'h5,        32'h5, 32'h0, 0, 0, 0);
        run("sra4",      rt_(6'b000011, 4), 32'h0,        32'h80000000, 32'hF8000000, 0, 0, 0);
        run("srl4",      rt_(6'b000010, 4), 32'h0,        32'h80000000, 32'h08000000, 0, 0, 0);
        run("srav",      rt_(6'b000111, 0), 32'h4,        32'h80000000, 32'hF8000000, 0, 0, 0);
        run("sllv",      rt_(6'b000100, 0), 32'h3,        32'h1, 32'h8, 0, 0, 0);
        run("nop_sll",   32'h0,             32'h0,        32'h1234, 32'h1234, 0, 0, 0);
        run("slt",       rt_(6'b101010, 0), 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0);
        run("sltu",      rt_(6'b101011, 0), 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0);
        run("lui",       it_(6'b001111),    32'h0,        32'h0000ABCD, 32'hABCD0000, 0, 0, 0);
        run("nor",       rt_(6'b100111, 0), 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F, 0, 0, 0);
        run("andi",      it_(6'b001100),    32'hFF00FF00, 32'h0000FFFF, 32'h0000FF00, 0, 0, 0);
        run("ori",       it_(6'b001101),    32'hFF000000, 32'h000000FF, 32'hFF0000FF, 0, 0, 0);
        run("xori",      it_(6'b001110),    32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0, 0, 0);
        run("ill_op3f",  it_(6'b111111),    32'h1,        32'h2, 32'h0, 0, 0, 1);
        run("ill_cop0",  {6'b010000, 5'b00001, 21'h0}, 32'h1, 32'h2, 32'h0, 0, 0, 1);
        run("ill_regim", {6'b000001, 5'b0, 5'b00010, 16'h0}, 32'h1, 32'h2, 32'h0, 0, 0, 1);
        run("ill_funct", rt_(6'b000001, 0), 32'h1,        32'h2, 32'h0, 0, 0, 1);
        run("mult",      rt_(6'b011000, 0), 32'h3,        32'h4, 32'h0, 0, 0, 0);
        run("eret",      {6'b010000, 1'b1, 19'h0, 6'b011000}, 32'h3, 32'h4, 32'h0, 0, 0, 0);
        run("ill_cop0b", {6'b010000, 1'b1, 19'h0, 6'b000000}, 32'h3, 32'h4, 32'h0, 0, 0, 1);
        run("mtc0",      {6'b010000, 5'b00100, 21'h0}, 32'h3, 32'h4, 32'h0, 0, 0, 0);
        run("bgezal",    {6'b000001, 5'b0, 5'b10001, 16'h0}, 32'h3, 32'h4, 32'h0, 0, 0, 0);
        run("jal",       it_(6'b000011),    32'h3,        32'h4, 32'h0, 0, 0, 0);
        run("addu_pre",  rt_(6'b100001, 0), 32'hFFFFFFF0, 32'h20, 32'h10, 1, 0, 0);

        // Asynchronous reset between edges, then capture on the first edge after release.
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 1'b0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(rt_(6'b100001, 0), 32'h2, 32'h3);
        @(posedge clk);
        #1;
        expect_out("post_rst", 1'b1, 32'h5, 0, 0, 0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
